// File: rtl/operand_fetch.sv
// operand_fetch: register-read / bypass stage between decode and execute.
//   Selects each source operand from zero, EX, MEM or WB bypass, or the
//   register file. Stalls on a load-use hazard against the EX stage and
//   registers the result into a one-entry valid/ready output slot.
// Ports:
//   clk, rst (sync active-high), flush
//   in_*        decode-side instruction (valid/ready handshake)
//   rf_rs*_*    combinational register file read port pair
//   ex/mem/wb_fwd_*  bypass sources, youngest first
//   out_*       execute-side instruction (valid/ready handshake)
//   stall_cnt   saturating count of load-use stall cycles

// One operand's source select. This is replicated per operand.
module operand_bypass #(
  parameter int XLEN = 64,
  parameter int RAW  = 5
) (
  input  logic [RAW-1:0]  rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_valid,
  input  logic [RAW-1:0]  ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_valid,
  input  logic [RAW-1:0]  mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_valid,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] src,
  output logic            ex_hit
);
  logic mem_hit, wb_hit;

  assign ex_hit  = ex_valid  && (ex_rd  == rs) && (ex_rd  != '0);
  assign mem_hit = mem_valid && (mem_rd == rs) && (mem_rd != '0);
  // WB hit also covers the regfile write landing on this same edge.
  assign wb_hit  = wb_valid  && (wb_rd  == rs) && (wb_rd  != '0);

  always_comb begin
    src = rf_data;
    if (rs == '0)   src = '0;
    else if (ex_hit)  src = ex_data;
    else if (mem_hit) src = mem_data;
    else if (wb_hit)  src = wb_data;
  end
endmodule

module operand_fetch #(
  parameter int XLEN = 64,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RAW-1:0]  in_rs1,
  input  logic [RAW-1:0]  in_rs2,
  input  logic [RAW-1:0]  in_rd,
  input  logic            in_rd_wen,
  input  logic            in_is_load,
  input  logic [XLEN-1:0] in_pc,
  output logic [RAW-1:0]  rf_rs1_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  output logic [RAW-1:0]  rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            ex_fwd_valid,
  input  logic [RAW-1:0]  ex_fwd_rd,
  input  logic            ex_fwd_is_load,
  input  logic [XLEN-1:0] ex_fwd_data,
  input  logic            mem_fwd_valid,
  input  logic [RAW-1:0]  mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_valid,
  input  logic [RAW-1:0]  wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_src1,
  output logic [XLEN-1:0] out_src2,
  output logic [RAW-1:0]  out_rd,
  output logic            out_rd_wen,
  output logic            out_is_load,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     stall_cnt
);
  localparam int NOPS = 2;

  logic [NOPS-1:0][RAW-1:0]  rs;
  logic [NOPS-1:0][XLEN-1:0] rf_data;
  logic [NOPS-1:0][XLEN-1:0] src;
  logic [NOPS-1:0]           ex_hit;
  logic                      hazard, capture;

  assign rf_rs1_addr = in_rs1;
  assign rf_rs2_addr = in_rs2;
  assign rs          = {in_rs2, in_rs1};
  assign rf_data     = {rf_rs2_data, rf_rs1_data};

  for (genvar i = 0; i < NOPS; i++) begin : g_op
    operand_bypass #(.XLEN(XLEN), .RAW(RAW)) u_byp (
      .rs       (rs[i]),
      .rf_data  (rf_data[i]),
      .ex_valid (ex_fwd_valid),
      .ex_rd    (ex_fwd_rd),
      .ex_data  (ex_fwd_data),
      .mem_valid(mem_fwd_valid),
      .mem_rd   (mem_fwd_rd),
      .mem_data (mem_fwd_data),
      .wb_valid (wb_fwd_valid),
      .wb_rd    (wb_fwd_rd),
      .wb_data  (wb_fwd_data),
      .src      (src[i]),
      .ex_hit   (ex_hit[i])
    );
  end

  // A load in EX has no data yet; hold the consumer until it reaches MEM.
  assign hazard   = in_valid && ex_fwd_is_load && (|ex_hit);
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_src1    <= '0;
      out_src2    <= '0;
      out_rd      <= '0;
      out_rd_wen  <= 1'b0;
      out_is_load <= 1'b0;
      out_pc      <= '0;
      stall_cnt   <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid   <= 1'b1;
        out_src1    <= src[0];
        out_src2    <= src[1];
        out_rd      <= in_rd;
        out_rd_wen  <= in_rd_wen;
        out_is_load <= in_is_load;
        out_pc      <= in_pc;
      end else if (!out_valid || out_ready) begin
        out_valid <= 1'b0;
      end
      if (hazard && !flush && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule
